// File: rtl/udp_tx_arbiter_pkg.sv
// Shared UDP definitions: FSM state encoding, header field widths and the
// header / payload-beat bundles used between the arbiter and its mux.
package udp_tx_arbiter_pkg;

    localparam int IP_W   = 32;
    localparam int PORT_W = 16;
    localparam int LEN_W  = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_ABORT   = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    typedef struct packed {
        logic [IP_W-1:0]   ip_dest_ip;
        logic [PORT_W-1:0] udp_source_port;
        logic [PORT_W-1:0] udp_dest_port;
        logic [LEN_W-1:0]  udp_length;
    } udp_hdr_t;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tvalid;
        logic       tlast;
        logic       tuser;
    } axis_beat_t;

endpackage

// File: rtl/udp_tx_mux.sv
// Two-requester header/payload multiplexer: forwards the granted requester's
// header and payload beat, and routes the downstream readies back to it only.
module udp_tx_mux
    import udp_tx_arbiter_pkg::*;
(
    input  logic             grant,
    input  logic [1:0]       hdr_valid,
    input  udp_hdr_t [1:0]   hdr,
    input  axis_beat_t [1:0] beat,
    input  logic             hdr_ready,
    input  logic             tready,
    output logic             sel_hdr_valid,
    output udp_hdr_t         sel_hdr,
    output axis_beat_t       sel_beat,
    output logic [1:0]       s_hdr_ready,
    output logic [1:0]       s_tready
);

    // select the owner's signals; the non-granted requester always sees ready low
    always_comb begin
        sel_hdr_valid      = hdr_valid[grant];
        sel_hdr            = hdr[grant];
        sel_beat           = beat[grant];
        s_hdr_ready        = 2'b00;
        s_tready           = 2'b00;
        s_hdr_ready[grant] = hdr_ready;
        s_tready[grant]    = tready;
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UDP transmit stack from two
// requesters (0: controller reply, 1: DAC/ADC data). A payload that stalls
// for TIMEOUT cycles is terminated with an error beat and the rest drained.
module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s0_hdr_valid,
    output logic                 s0_hdr_ready,
    input  logic [IP_W-1:0]      s0_ip_dest_ip,
    input  logic [PORT_W-1:0]    s0_udp_source_port,
    input  logic [PORT_W-1:0]    s0_udp_dest_port,
    input  logic [LEN_W-1:0]     s0_udp_length,
    input  logic [7:0]           s0_payload_axis_tdata,
    input  logic                 s0_payload_axis_tvalid,
    input  logic                 s0_payload_axis_tlast,
    input  logic                 s0_payload_axis_tuser,
    output logic                 s0_payload_axis_tready,
    input  logic                 s1_hdr_valid,
    output logic                 s1_hdr_ready,
    input  logic [IP_W-1:0]      s1_ip_dest_ip,
    input  logic [PORT_W-1:0]    s1_udp_source_port,
    input  logic [PORT_W-1:0]    s1_udp_dest_port,
    input  logic [LEN_W-1:0]     s1_udp_length,
    input  logic [7:0]           s1_payload_axis_tdata,
    input  logic                 s1_payload_axis_tvalid,
    input  logic                 s1_payload_axis_tlast,
    input  logic                 s1_payload_axis_tuser,
    output logic                 s1_payload_axis_tready,
    output logic                 m_hdr_valid,
    input  logic                 m_hdr_ready,
    output logic [IP_W-1:0]      m_ip_dest_ip,
    output logic [PORT_W-1:0]    m_udp_source_port,
    output logic [PORT_W-1:0]    m_udp_dest_port,
    output logic [LEN_W-1:0]     m_udp_length,
    output logic [7:0]           m_payload_axis_tdata,
    output logic                 m_payload_axis_tvalid,
    output logic                 m_payload_axis_tlast,
    output logic                 m_payload_axis_tuser,
    input  logic                 m_payload_axis_tready,
    output logic                 busy,
    output logic                 grant,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
    output logic [CNT_WIDTH-1:0] abort_cnt
);

    localparam int              SW         = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]   STALL_LAST = SW'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]       state;
    logic             rr_pri;   // requester that wins when both ask
    logic [SW-1:0]    stall;
    logic             pick;
    logic             hdr_ready_g;
    logic             tready_g;
    logic             sel_hdr_valid;
    udp_hdr_t         sel_hdr;
    axis_beat_t       sel_beat;
    udp_hdr_t [1:0]   s_hdr;
    axis_beat_t [1:0] s_beat;
    logic [1:0]       s_hdr_ready;
    logic [1:0]       s_tready;

    assign s_hdr[0]  = '{s0_ip_dest_ip, s0_udp_source_port, s0_udp_dest_port, s0_udp_length};
    assign s_hdr[1]  = '{s1_ip_dest_ip, s1_udp_source_port, s1_udp_dest_port, s1_udp_length};
    assign s_beat[0] = '{s0_payload_axis_tdata, s0_payload_axis_tvalid,
                         s0_payload_axis_tlast, s0_payload_axis_tuser};
    assign s_beat[1] = '{s1_payload_axis_tdata, s1_payload_axis_tvalid,
                         s1_payload_axis_tlast, s1_payload_axis_tuser};

    // a lone requester wins outright; with both, the one not served last
    assign pick = (s0_hdr_valid & s1_hdr_valid) ? rr_pri : s1_hdr_valid;

    assign hdr_ready_g = (state == ST_HDR) & m_hdr_ready;
    assign tready_g    = (state == ST_PAYLOAD) ? m_payload_axis_tready : (state == ST_DRAIN);
    assign busy        = (state != ST_IDLE);

    udp_tx_mux u_mux (
        .grant         (grant),
        .hdr_valid     ({s1_hdr_valid, s0_hdr_valid}),
        .hdr           (s_hdr),
        .beat          (s_beat),
        .hdr_ready     (hdr_ready_g),
        .tready        (tready_g),
        .sel_hdr_valid (sel_hdr_valid),
        .sel_hdr       (sel_hdr),
        .sel_beat      (sel_beat),
        .s_hdr_ready   (s_hdr_ready),
        .s_tready      (s_tready)
    );

    assign s0_hdr_ready           = s_hdr_ready[0];
    assign s1_hdr_ready           = s_hdr_ready[1];
    assign s0_payload_axis_tready = s_tready[0];
    assign s1_payload_axis_tready = s_tready[1];

    assign m_hdr_valid       = (state == ST_HDR) & sel_hdr_valid;
    assign m_ip_dest_ip      = sel_hdr.ip_dest_ip;
    assign m_udp_source_port = sel_hdr.udp_source_port;
    assign m_udp_dest_port   = sel_hdr.udp_dest_port;
    assign m_udp_length      = sel_hdr.udp_length;

    // payload pass-through, replaced by a zero error/terminator beat while aborting
    always_comb begin
        m_payload_axis_tvalid = 1'b0;
        m_payload_axis_tdata  = sel_beat.tdata;
        m_payload_axis_tlast  = sel_beat.tlast;
        m_payload_axis_tuser  = sel_beat.tuser;
        if (state == ST_PAYLOAD) begin
            m_payload_axis_tvalid = sel_beat.tvalid;
        end else if (state == ST_ABORT) begin
            m_payload_axis_tvalid = 1'b1;
            m_payload_axis_tdata  = 8'h00;
            m_payload_axis_tlast  = 1'b1;
            m_payload_axis_tuser  = 1'b1;
        end
    end

    // packet FSM, round-robin pointer, stall timer and statistics counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= 1'b0;
            rr_pri    <= 1'b0;
            stall     <= '0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            abort_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s0_hdr_valid | s1_hdr_valid) begin
                        grant  <= pick;
                        rr_pri <= ~pick;
                        state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    stall <= '0;
                    if (sel_hdr_valid & m_hdr_ready) state <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    // a valid beat clears the timer even on the cycle it would expire
                    if (sel_beat.tvalid) begin
                        stall <= '0;
                        if (m_payload_axis_tready & sel_beat.tlast) begin
                            state <= ST_IDLE;
                            if (grant) pkt_cnt1 <= pkt_cnt1 + CNT_ONE;
                            else       pkt_cnt0 <= pkt_cnt0 + CNT_ONE;
                        end
                    end else if (stall == STALL_LAST) begin
                        stall <= '0;
                        state <= ST_ABORT;
                    end else begin
                        stall <= stall + 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (m_payload_axis_tready) begin
                        abort_cnt <= abort_cnt + CNT_ONE;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sel_beat.tvalid & sel_beat.tlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
